// File: rtl/uart_cmd_ctrl.sv
`timescale 1ns/1ps
// UART command controller: decodes 'W' ADDR DATA / 'R' ADDR frames into register strobes and one response byte.
// Strobes 1 cycle after the last frame byte; the response waits in SEND while tx_busy is high, extra rx bytes are dropped.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rd_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       err_timeout,
    output logic       err_overrun
);
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    OP_WRITE = 8'h57;
    localparam logic [7:0]    OP_READ  = 8'h52;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ, WAIT_RD, SEND} state_t;

    state_t        state;
    logic          wr_flag;
    logic [7:0]    resp;
    logic [CW-1:0] to_cnt;
    logic          to_hit;
    logic [CW-1:0] to_cnt_inc;

    assign to_hit     = (to_cnt == TO_LAST);
    assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_flag     <= 1'b0;
            resp        <= 8'h00;
            to_cnt      <= '0;
            reg_addr    <= 8'h00;
            reg_wdata   <= 8'h00;
            tx_data     <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                            wr_flag <= (rx_byte == OP_WRITE);
                            state   <= GET_ADDR;
                        end else begin
                            resp  <= NAK_BYTE;
                            state <= SEND;
                        end
                    end
                end
                // A byte arriving on the expiry cycle loses to the timeout and is silently dropped.
                GET_ADDR, GET_DATA: begin
                    if (to_hit) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (rx_valid) begin
                        to_cnt <= '0;
                        if (state == GET_ADDR) begin
                            reg_addr <= rx_byte;
                            if (wr_flag) begin
                                state <= GET_DATA;
                            end else begin
                                reg_rd_en <= 1'b1;
                                state     <= READ;
                            end
                        end else begin
                            reg_wdata <= rx_byte;
                            reg_wr_en <= 1'b1;
                            state     <= WRITE;
                        end
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end
                WRITE: begin
                    err_overrun <= rx_valid;
                    resp        <= ACK_BYTE;
                    state       <= SEND;
                end
                READ: begin
                    err_overrun <= rx_valid;
                    to_cnt      <= '0;
                    state       <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (to_hit) begin
                        err_timeout <= 1'b1;
                        resp        <= NAK_BYTE;
                        state       <= SEND;
                    end else begin
                        err_overrun <= rx_valid;
                        if (reg_rd_valid) begin
                            resp  <= reg_rdata;
                            state <= SEND;
                        end else begin
                            to_cnt <= to_cnt_inc;
                        end
                    end
                end
                SEND: begin
                    err_overrun <= rx_valid;
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= resp;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
